// File: rtl/bitstream_flag_serializer.sv
// Expands the entropy encoder's compressed per-cycle records (literal or run form)
// into a one-byte-per-cycle stream with valid/ready handshake and frame-end pulses.
module bitstream_flag_serializer #(
   parameter int BITSTREAM_WIDTH = 8,
   parameter int RUN_WIDTH       = 8,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                            top_clk,
   input  logic                            top_reset,
   input  logic [BITSTREAM_WIDTH-1:0]      in_b1,
   input  logic [BITSTREAM_WIDTH-1:0]      in_b2,
   input  logic [BITSTREAM_WIDTH-1:0]      in_b3,
   input  logic [BITSTREAM_WIDTH-1:0]      in_b4,
   input  logic [BITSTREAM_WIDTH-1:0]      in_b5,
   input  logic [2:0]                      in_flag,
   input  logic                            in_last,
   output logic [BITSTREAM_WIDTH-1:0]      out_byte,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_frame_done,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            err_overflow,
   output logic                            err_invalid
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic                       last;
      logic [2:0]                 flag;
      logic [BITSTREAM_WIDTH-1:0] b5;
      logic [BITSTREAM_WIDTH-1:0] b4;
      logic [BITSTREAM_WIDTH-1:0] b3;
      logic [BITSTREAM_WIDTH-1:0] b2;
      logic [BITSTREAM_WIDTH-1:0] b1;
   } rec_t;

   typedef enum logic [2:0] {
      S_IDLE, S_B1, S_RUN, S_LIT2, S_LIT3, S_B4, S_B5, S_DONE
   } state_t;

   rec_t                       fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]              count_q, count_d;
   logic                       err_ovf_q, err_ovf_d;
   logic                       err_inv_q, err_inv_d;

   state_t                     state_q, state_d;
   rec_t                       rec_q, rec_d;
   logic [RUN_WIDTH-1:0]       run_cnt_q, run_cnt_d;
   logic                       out_valid_q, out_valid_d;
   logic [BITSTREAM_WIDTH-1:0] out_byte_q, out_byte_d;
   logic                       frame_done_q, frame_done_d;

   logic                       push_req_s, push_ok_s, pop_s;
   logic                       fifo_empty_s, fifo_full_s, slot_free_s;
   logic                       emit_s, end_rec_s, start_s;
   logic [BITSTREAM_WIDTH-1:0] emit_byte_s;
   rec_t                       in_rec_s, head_s;

   // Invalid flag 4 is stored as a zero-byte marker so only in_last survives it.
   assign in_rec_s     = '{last: in_last,
                           flag: (in_flag == 3'd4) ? 3'd0 : in_flag,
                           b5: in_b5, b4: in_b4, b3: in_b3, b2: in_b2, b1: in_b1};
   assign head_s       = fifo_mem_q[rd_ptr_q];
   assign fifo_empty_s = (count_q == {CW{1'b0}});
   assign fifo_full_s  = (count_q == CW'(FIFO_DEPTH));
   assign slot_free_s  = ~out_valid_q | out_ready;

   // FIFO bookkeeping and sticky error flags.
   always_comb begin
      push_req_s = in_last | ((in_flag != 3'd0) & (in_flag != 3'd4));
      push_ok_s  = push_req_s & (~fifo_full_s | pop_s);
      wr_ptr_d   = push_ok_s ? wr_ptr_q + AW'(1'b1) : wr_ptr_q;
      rd_ptr_d   = pop_s ? rd_ptr_q + AW'(1'b1) : rd_ptr_q;
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CW'(1'b1);
         2'b01:   count_d = count_q - CW'(1'b1);
         default: count_d = count_q;
      endcase
      err_ovf_d = err_ovf_q | (push_req_s & ~push_ok_s);
      err_inv_d = err_inv_q | (in_flag == 3'd4);
   end

   // Record storage; contents need no reset because count gates every read.
   always_ff @(posedge top_clk) begin
      if (push_ok_s) begin
         fifo_mem_q[wr_ptr_q] <= in_rec_s;
      end
   end

   // Byte-generation FSM: each state produces one byte into the output register.
   always_comb begin
      state_d      = state_q;
      rec_d        = rec_q;
      run_cnt_d    = run_cnt_q;
      out_valid_d  = out_valid_q & ~out_ready;
      out_byte_d   = out_byte_q;
      frame_done_d = 1'b0;
      pop_s        = 1'b0;
      emit_s       = 1'b0;
      emit_byte_s  = {BITSTREAM_WIDTH{1'b0}};
      end_rec_s    = 1'b0;
      start_s      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty_s && slot_free_s) start_s = 1'b1;
            else                              state_d = S_IDLE;
         end
         S_B1: begin
            if (slot_free_s) begin
               emit_s      = 1'b1;
               emit_byte_s = rec_q.b1;
               if (rec_q.flag == 3'd1)                  end_rec_s = 1'b1;
               else if (rec_q.flag <= 3'd3)             state_d   = S_LIT2;
               else if (run_cnt_q != {RUN_WIDTH{1'b0}}) state_d   = S_RUN;
               else if (rec_q.flag >= 3'd6)             state_d   = S_B4;
               else                                     end_rec_s = 1'b1;
            end else begin
               state_d = S_B1;
            end
         end
         S_LIT2: begin
            if (slot_free_s) begin
               emit_s      = 1'b1;
               emit_byte_s = rec_q.b2;
               if (rec_q.flag == 3'd3) state_d   = S_LIT3;
               else                    end_rec_s = 1'b1;
            end else begin
               state_d = S_LIT2;
            end
         end
         S_LIT3: begin
            if (slot_free_s) begin
               emit_s      = 1'b1;
               emit_byte_s = rec_q.b3;
               end_rec_s   = 1'b1;
            end else begin
               state_d = S_LIT3;
            end
         end
         S_RUN: begin
            if (slot_free_s) begin
               emit_s      = 1'b1;
               emit_byte_s = rec_q.b2;
               run_cnt_d   = run_cnt_q - RUN_WIDTH'(1'b1);
               if (run_cnt_q == RUN_WIDTH'(1'b1)) begin
                  if (rec_q.flag >= 3'd6) state_d   = S_B4;
                  else                    end_rec_s = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_B4: begin
            if (slot_free_s) begin
               emit_s      = 1'b1;
               emit_byte_s = rec_q.b4;
               if (rec_q.flag == 3'd7) state_d   = S_B5;
               else                    end_rec_s = 1'b1;
            end else begin
               state_d = S_B4;
            end
         end
         S_B5: begin
            if (slot_free_s) begin
               emit_s      = 1'b1;
               emit_byte_s = rec_q.b5;
               end_rec_s   = 1'b1;
            end else begin
               state_d = S_B5;
            end
         end
         S_DONE: begin
            // Waiting for the slot guarantees the pulse follows the last byte's acceptance.
            if (slot_free_s) begin
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (emit_s) begin
         out_valid_d = 1'b1;
         out_byte_d  = emit_byte_s;
      end else begin
         out_byte_d = out_byte_q;
      end

      // Chain straight into the next record only while the sink is draining.
      if (end_rec_s) begin
         if (rec_q.last)                      state_d = S_DONE;
         else if (!fifo_empty_s && out_ready) start_s = 1'b1;
         else                                 state_d = S_IDLE;
      end else begin
         start_s = start_s;
      end

      if (start_s) begin
         pop_s     = 1'b1;
         rec_d     = head_s;
         run_cnt_d = head_s.b3[RUN_WIDTH-1:0];
         state_d   = (head_s.flag == 3'd0) ? S_DONE : S_B1;
      end else begin
         pop_s = 1'b0;
      end
   end

   // State, pointers, output register and error flags.
   always_ff @(posedge top_clk) begin
      if (top_reset) begin
         wr_ptr_q     <= {AW{1'b0}};
         rd_ptr_q     <= {AW{1'b0}};
         count_q      <= {CW{1'b0}};
         err_ovf_q    <= 1'b0;
         err_inv_q    <= 1'b0;
         state_q      <= S_IDLE;
         rec_q        <= '{default: '0};
         run_cnt_q    <= {RUN_WIDTH{1'b0}};
         out_valid_q  <= 1'b0;
         out_byte_q   <= {BITSTREAM_WIDTH{1'b0}};
         frame_done_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         err_ovf_q    <= err_ovf_d;
         err_inv_q    <= err_inv_d;
         state_q      <= state_d;
         rec_q        <= rec_d;
         run_cnt_q    <= run_cnt_d;
         out_valid_q  <= out_valid_d;
         out_byte_q   <= out_byte_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign out_byte       = out_byte_q;
   assign out_valid      = out_valid_q;
   assign out_frame_done = frame_done_q;
   assign fifo_count     = count_q;
   assign err_overflow   = err_ovf_q;
   assign err_invalid    = err_inv_q;

endmodule

// File: tb/tb_bitstream_flag_serializer.sv
// Directed bench for bitstream_flag_serializer: literal, run, backpressure,
// overflow, frame-end, invalid-flag and mid-record reset scenarios.
module tb_bitstream_flag_serializer;

   logic       top_clk = 1'b0;
   logic       top_reset;
   logic [7:0] in_b1, in_b2, in_b3, in_b4, in_b5;
   logic [2:0] in_flag;
   logic       in_last;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_ready;
   logic       out_frame_done;
   logic [3:0] fifo_count;
   logic       err_overflow;
   logic       err_invalid;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] acc_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] lit_exp [6];
   logic [7:0] fd_vec;
   int         ff_cnt;

   bitstream_flag_serializer #(
      .BITSTREAM_WIDTH(8), .RUN_WIDTH(8), .FIFO_DEPTH(8)
   ) dut (
      .top_clk(top_clk), .top_reset(top_reset),
      .in_b1(in_b1), .in_b2(in_b2), .in_b3(in_b3), .in_b4(in_b4), .in_b5(in_b5),
      .in_flag(in_flag), .in_last(in_last),
      .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
      .out_frame_done(out_frame_done), .fifo_count(fifo_count),
      .err_overflow(err_overflow), .err_invalid(err_invalid)
   );

   always #5 top_clk = ~top_clk;

   // Sink model: record every byte handed over at a rising edge.
   always @(posedge top_clk) begin
      if (!top_reset && out_valid && out_ready) acc_q.push_back(out_byte);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_seq(input string tag, input logic [7:0] exp[$]);
      chk({tag, "_len"}, acc_q.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         chk(tag, (i < acc_q.size()) ? {24'h0, acc_q[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
   endtask

   task automatic drive_rec(input logic [2:0] f, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                            input logic last);
      in_flag = f; in_b1 = b1; in_b2 = b2; in_b3 = b3; in_b4 = b4; in_b5 = b5; in_last = last;
   endtask

   task automatic idle_in();
      drive_rec(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge top_clk);
   endtask

   initial begin
      idle_in();
      out_ready = 1'b1;
      top_reset = 1'b1;
      lit_exp   = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32};
      cycles(3);
      top_reset = 1'b0;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_byte", out_byte, 8'h00);
      chk("rst_count", fifo_count, 4'd0);
      chk("rst_ovf", err_overflow, 1'b0);
      chk("rst_inv", err_invalid, 1'b0);
      chk("rst_done", out_frame_done, 1'b0);

      // Literal mix on consecutive cycles; first byte two edges after the push.
      acc_q.delete();
      drive_rec(3'd1, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      cycles(1);
      chk("lit_lat0", out_valid, 1'b0);
      drive_rec(3'd3, 8'h21, 8'h22, 8'h23, 8'h00, 8'h00, 1'b0);
      cycles(1);
      chk("lit_lat1", out_valid, 1'b0);
      drive_rec(3'd2, 8'h31, 8'h32, 8'h00, 8'h00, 8'h00, 1'b0);
      cycles(1);
      idle_in();
      chk("lit_v0", out_valid, 1'b1);
      chk("lit_b0", out_byte, lit_exp[0]);
      for (int i = 1; i < 6; i++) begin
         cycles(1);
         chk("lit_v", out_valid, 1'b1);
         chk("lit_b", out_byte, lit_exp[i]);
      end
      cycles(1);
      chk("lit_end", out_valid, 1'b0);
      exp_q = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32};
      chk_seq("lit_seq", exp_q);

      // Run form flag 7, count 3.
      acc_q.delete();
      drive_rec(3'd7, 8'h40, 8'hFF, 8'd3, 8'h7A, 8'h05, 1'b0);
      cycles(1);
      idle_in();
      cycles(12);
      exp_q = '{8'h40, 8'hFF, 8'hFF, 8'hFF, 8'h7A, 8'h05};
      chk_seq("run7", exp_q);

      // Run form flag 5 with zero count.
      acc_q.delete();
      drive_rec(3'd5, 8'h40, 8'hFF, 8'd0, 8'h7A, 8'h05, 1'b0);
      cycles(1);
      idle_in();
      cycles(8);
      exp_q = '{8'h40};
      chk_seq("run5_zero", exp_q);

      // Run form flag 6 with maximum count: 257 bytes.
      acc_q.delete();
      drive_rec(3'd6, 8'h40, 8'hFF, 8'd255, 8'h7A, 8'h05, 1'b0);
      cycles(1);
      idle_in();
      cycles(270);
      chk("run6_len", acc_q.size(), 257);
      chk("run6_first", (acc_q.size() > 0) ? acc_q[0] : 8'h00, 8'h40);
      chk("run6_last", (acc_q.size() == 257) ? acc_q[256] : 8'h00, 8'h7A);
      ff_cnt = 0;
      for (int i = 1; i < 256; i++)
         if (i < acc_q.size() && acc_q[i] == 8'hFF) ff_cnt++;
      chk("run6_ff", ff_cnt, 255);

      // Backpressure: sink stalls for two cycles while A2 is presented.
      acc_q.delete();
      drive_rec(3'd3, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 1'b0);
      cycles(1);
      idle_in();
      cycles(2);
      chk("bp_v1", out_valid, 1'b1);
      chk("bp_b1", out_byte, 8'hA1);
      cycles(1);
      chk("bp_b2", out_byte, 8'hA2);
      out_ready = 1'b0;
      cycles(1);
      chk("bp_hold_v", out_valid, 1'b1);
      chk("bp_hold1", out_byte, 8'hA2);
      cycles(1);
      chk("bp_hold2", out_byte, 8'hA2);
      out_ready = 1'b1;
      cycles(1);
      chk("bp_b3", out_byte, 8'hA3);
      cycles(3);
      exp_q = '{8'hA1, 8'hA2, 8'hA3};
      chk_seq("bp_seq", exp_q);

      // Overflow: ten records into a stalled sink.
      acc_q.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive_rec(3'd1, 8'(i), 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
         cycles(1);
      end
      idle_in();
      cycles(1);
      chk("ovf_count", fifo_count, 4'd8);
      chk("ovf_flag", err_overflow, 1'b1);
      chk("ovf_head", out_byte, 8'h00);
      out_ready = 1'b1;
      cycles(40);
      exp_q.delete();
      for (int i = 0; i < 9; i++) exp_q.push_back(8'(i));
      chk_seq("ovf_seq", exp_q);
      chk("ovf_sticky", err_overflow, 1'b1);
      chk("ovf_drained", fifo_count, 4'd0);

      // Frame end: last-flagged record followed by a bare marker.
      acc_q.delete();
      fd_vec = 8'h00;
      drive_rec(3'd2, 8'hC0, 8'hC1, 8'h00, 8'h00, 8'h00, 1'b1);
      cycles(1);
      fd_vec[0] = out_frame_done;
      drive_rec(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      cycles(1);
      fd_vec[1] = out_frame_done;
      idle_in();
      for (int k = 2; k < 8; k++) begin
         cycles(1);
         fd_vec[k] = out_frame_done;
      end
      chk("frame_pulses", fd_vec, 8'b0101_0000);
      exp_q = '{8'hC0, 8'hC1};
      chk_seq("frame_seq", exp_q);

      // Invalid flag: error only, no bytes.
      acc_q.delete();
      chk("inv_pre", err_invalid, 1'b0);
      drive_rec(3'd4, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 1'b0);
      cycles(1);
      idle_in();
      cycles(5);
      chk("inv_flag", err_invalid, 1'b1);
      chk("inv_bytes", acc_q.size(), 0);
      chk("inv_count", fifo_count, 4'd0);

      // Reset in the middle of a 200-byte run.
      acc_q.delete();
      drive_rec(3'd5, 8'h40, 8'h55, 8'd200, 8'h00, 8'h00, 1'b0);
      cycles(1);
      idle_in();
      cycles(20);
      chk("mid_v", out_valid, 1'b1);
      chk("mid_b", out_byte, 8'h55);
      top_reset = 1'b1;
      cycles(1);
      top_reset = 1'b0;
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_count", fifo_count, 4'd0);
      chk("mrst_ovf", err_overflow, 1'b0);
      chk("mrst_inv", err_invalid, 1'b0);
      cycles(3);
      chk("mrst_quiet", out_valid, 1'b0);
      acc_q.delete();
      drive_rec(3'd3, 8'h61, 8'h62, 8'h63, 8'h00, 8'h00, 1'b0);
      cycles(1);
      idle_in();
      cycles(8);
      exp_q = '{8'h61, 8'h62, 8'h63};
      chk_seq("mrst_seq", exp_q);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
